// File: rtl/shift_seq_pkg.sv
// rtl/shift_seq_pkg.sv - op, register-mode and FSM state encodings for shift_seq_ctrl
package shift_seq_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_SHR  = 2'b01,
    OP_SHL  = 2'b10,
    OP_ROR  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    MODE_LOAD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_HOLD = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  // Rotate right is a shift right whose fill is the outgoing bit 0.
  function automatic mode_e op_mode(op_e op);
    case (op)
      OP_LOAD: return MODE_LOAD;
      OP_SHL:  return MODE_SHL;
      default: return MODE_SHR;
    endcase
  endfunction

endpackage

// File: rtl/shift_seq_ctrl.sv
// rtl/shift_seq_ctrl.sv - command sequencer driving a universal shift register
// Optional abort input / aborted output enabled by SHIFT_SEQ_ABORT_EN.
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             cmd_fill,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [WIDTH-1:0] reg_q,
  output logic [WIDTH-1:0] sr_in,
  output logic             sr_s1,
  output logic             sr_s0,
  output logic             sr_enable,
  output logic             sr_left_in,
  output logic             sr_right_in,
  output logic             busy,
  output logic             done
`ifdef SHIFT_SEQ_ABORT_EN
  ,
  input  logic             abort,
  output logic             aborted
`endif
);

  state_e           state;
  op_e              op_q;
  logic [CNT_W-1:0] cnt_q;
  logic             fill_q;
  logic [WIDTH-1:0] data_q;
  logic             abort_hit;
  logic             aborted_q;
  mode_e            mode;
  logic [WIDTH-2:0] reg_q_unused;

  assign reg_q_unused = reg_q[WIDTH-1:1];

`ifdef SHIFT_SEQ_ABORT_EN
  assign abort_hit = abort;
  assign aborted   = (state == ST_DONE) && aborted_q;
`else
  assign abort_hit = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      op_q      <= OP_LOAD;
      cnt_q     <= '0;
      fill_q    <= 1'b0;
      data_q    <= '0;
      aborted_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          aborted_q <= 1'b0;
          if (cmd_valid) begin
            op_q   <= op_e'(cmd_op);
            cnt_q  <= cmd_count;
            fill_q <= cmd_fill;
            data_q <= cmd_data;
            if (op_e'(cmd_op) == OP_LOAD)
              state <= ST_LOAD;
            else if (cmd_count != '0)
              state <= ST_SHIFT;
            else
              state <= ST_DONE;
          end
        end
        ST_LOAD: begin
          aborted_q <= abort_hit;
          state     <= ST_DONE;
        end
        ST_SHIFT: begin
          if (abort_hit) begin
            aborted_q <= 1'b1;
            state     <= ST_DONE;
          end else if (cnt_q == CNT_W'(1)) begin
            state <= ST_DONE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Enable is also gated by reset so a mid-command reset cuts off the shift in flight.
  always_comb begin
    mode        = MODE_HOLD;
    sr_in       = '0;
    sr_enable   = 1'b0;
    sr_left_in  = 1'b0;
    sr_right_in = 1'b0;
    case (state)
      ST_LOAD: begin
        mode      = MODE_LOAD;
        sr_in     = data_q;
        sr_enable = !reset && !abort_hit;
      end
      ST_SHIFT: begin
        mode      = op_mode(op_q);
        sr_enable = !reset && !abort_hit;
        case (op_q)
          OP_SHL:  sr_left_in  = fill_q;
          OP_ROR:  sr_right_in = reg_q[0];
          default: sr_right_in = fill_q;
        endcase
      end
      default: ;
    endcase
  end

  assign sr_s1     = mode[1];
  assign sr_s0     = mode[0];
  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb/tb_shift_seq_ctrl.sv - scoreboard bench for shift_seq_ctrl with a behavioural shift register
module tb_shift_seq_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [2:0] cmd_count = 3'd0;
  logic       cmd_fill = 1'b0;
  logic [3:0] cmd_data = 4'd0;
  logic [3:0] reg_q = 4'd0;
  logic [3:0] sr_in;
  logic       sr_s1, sr_s0, sr_enable, sr_left_in, sr_right_in, busy, done;
  logic       abort = 1'b0;
  logic       aborted;

  shift_seq_ctrl #(.WIDTH(4), .CNT_W(3)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_count(cmd_count), .cmd_fill(cmd_fill), .cmd_data(cmd_data),
    .reg_q(reg_q), .sr_in(sr_in), .sr_s1(sr_s1), .sr_s0(sr_s0),
    .sr_enable(sr_enable), .sr_left_in(sr_left_in), .sr_right_in(sr_right_in),
    .busy(busy), .done(done)
`ifdef SHIFT_SEQ_ABORT_EN
    , .abort(abort), .aborted(aborted)
`endif
  );

`ifndef SHIFT_SEQ_ABORT_EN
  assign aborted = 1'b0;
`endif

  always #5 clock = ~clock;

  // Behavioural universal shift register; it keeps its contents across reset.
  always @(posedge clock) begin
    if (sr_enable) begin
      case ({sr_s1, sr_s0})
        2'b00: reg_q <= sr_in;
        2'b01: reg_q <= {sr_right_in, reg_q[3:1]};
        2'b10: reg_q <= {reg_q[2:0], sr_left_in};
        default: reg_q <= reg_q;
      endcase
    end
  end

  typedef struct {
    logic [1:0] op;
    logic       fill;
    logic [3:0] data;
    logic [3:0] val;
    int         enables;
    int         lat;
    logic       abrt;
  } exp_t;

  exp_t       exp_q[$];
  int         n_tests = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         accept_edge = 0;
  int         en_cnt = 0;
  logic [3:0] model_val = 4'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [3:0] apply(input logic [1:0] op, input int k, input logic f,
                                       input logic [3:0] d, input logic [3:0] v);
    logic [3:0] r;
    r = v;
    if (op == 2'd0) return d;
    for (int i = 0; i < k; i++) begin
      case (op)
        2'd1: r = (r >> 1) | ({3'b000, f} << 3);
        2'd2: r = (r << 1) | {3'b000, f};
        default: r = (r >> 1) | ({3'b000, r[0]} << 3);
      endcase
    end
    return r;
  endfunction

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: counts enable cycles, checks pin settings, pops on done.
  always @(negedge clock) begin
    logic [5:0] act, expv;
    exp_t e;
    if (reset) begin
      en_cnt = 0;
    end else begin
      if (cmd_valid && cmd_ready) begin
        accept_edge = cyc + 1;
        en_cnt = 0;
      end
      if (sr_enable) begin
        en_cnt++;
        if (exp_q.size() > 0) begin
          e = exp_q[0];
          case (e.op)
            2'd0: begin act = {sr_s1, sr_s0, sr_in};     expv = {2'b00, e.data};          end
            2'd1: begin act = {sr_s1, sr_s0, 3'b000, sr_right_in}; expv = {2'b01, 3'b000, e.fill}; end
            2'd2: begin act = {sr_s1, sr_s0, 3'b000, sr_left_in};  expv = {2'b10, 3'b000, e.fill}; end
            default: begin act = {sr_s1, sr_s0, 3'b000, sr_right_in}; expv = {2'b01, 3'b000, reg_q[0]}; end
          endcase
          check("pins", 32'(act), 32'(expv));
        end
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("reg_q", 32'(reg_q), 32'(e.val));
          check("enables", 32'(en_cnt), 32'(e.enables));
          check("latency", 32'(cyc + 1 - accept_edge), 32'(e.lat));
          check("ready_in_done", 32'(cmd_ready), 32'd0);
          check("aborted", 32'(aborted), 32'(e.abrt));
        end
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [2:0] cnt, input logic f,
                      input logic [3:0] d, input int model_cnt, input logic abrt, input bit push);
    exp_t e;
    int   k;
    bit   ok;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clock); #1;
      if (cmd_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      check("ready_timeout", 32'(cmd_ready), 32'd1);
      return;
    end
    k = (model_cnt < 0) ? int'(cnt) : model_cnt;
    cmd_op = op; cmd_count = cnt; cmd_fill = f; cmd_data = d; cmd_valid = 1'b1;
    model_val = apply(op, k, f, d, model_val);
    if (push) begin
      e.op = op; e.fill = f; e.data = d; e.val = model_val; e.abrt = abrt;
      e.enables = (op == 2'd0) ? 1 : k;
      if (abrt) e.lat = k + 2;
      else if (op == 2'd0) e.lat = 2;
      else e.lat = (cnt == 0) ? 1 : int'(cnt) + 1;
      exp_q.push_back(e);
    end
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom); cmd_count = 3'($urandom);
    cmd_fill = 1'($urandom); cmd_data = 4'($urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (exp_q.size() == 0) break;
    end
    if (exp_q.size() != 0) begin
      check("done_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    check("reset_ready", 32'(cmd_ready), 32'd1);
    check("reset_outs", 32'({busy, done, sr_enable, sr_s1, sr_s0, sr_left_in, sr_right_in}),
          32'b0001100);
    check("reset_sr_in", 32'(sr_in), 32'd0);

    send(2'd0, 3'd0, 1'b0, 4'b0110, -1, 1'b0, 1'b1); drain();
    send(2'd1, 3'd2, 1'b1, 4'd0,    -1, 1'b0, 1'b1); drain();
    send(2'd0, 3'd0, 1'b0, 4'b0110, -1, 1'b0, 1'b1); drain();
    send(2'd2, 3'd3, 1'b0, 4'd0,    -1, 1'b0, 1'b1); drain();
    send(2'd0, 3'd0, 1'b0, 4'b1001, -1, 1'b0, 1'b1); drain();
    send(2'd3, 3'd5, 1'b0, 4'd0,    -1, 1'b0, 1'b1); drain();
    send(2'd1, 3'd0, 1'b1, 4'd0,    -1, 1'b0, 1'b1); drain();

    // Reset during the third shift of a seven-shift command.
    send(2'd0, 3'd0, 1'b0, 4'b0110, -1, 1'b0, 1'b1); drain();
    send(2'd2, 3'd7, 1'b1, 4'd0, 2, 1'b0, 1'b0);
    @(posedge clock); @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    check("rst_mid_ready", 32'(cmd_ready), 32'd1);
    check("rst_mid_reg_q", 32'(reg_q), 32'(model_val));
    repeat (4) @(negedge clock);

`ifdef SHIFT_SEQ_ABORT_EN
    send(2'd0, 3'd0, 1'b0, 4'b0110, -1, 1'b0, 1'b1); drain();
    send(2'd2, 3'd7, 1'b1, 4'd0, 2, 1'b1, 1'b1);
    @(posedge clock); @(posedge clock); #1 abort = 1'b1;
    @(posedge clock); #1 abort = 1'b0;
    drain();
`endif

    for (int i = 0; i < 40; i++) begin
      send(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 1'($urandom),
           4'($urandom), -1, 1'b0, 1'b1);
      if ($urandom_range(0, 2) == 0) drain();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
